track_motor_scheduler: RTL and testbench
========================================

# track_motor_scheduler

Frame-rate controller that sits between the red-object tracker and the pan/tilt stepper drivers. Once per video frame it samples the tracker's aim point and status, runs a TRACK/HOLD/SEARCH/HOME state machine, and issues one signed pan/tilt step command over a valid/ready handshake. It maintains the accumulated pan/tilt position, so the search sweep and return-to-home never exceed mechanical limits.

## Interface
- `CX`, 320: screen-centre x, in pixels.
- `CY`, 240: screen-centre y, in pixels.
- `DEADBAND`, 10: per-axis error magnitude, in pixels, that produces a zero step.
- `GAIN_SHIFT`, 3: step = error >>> GAIN_SHIFT.
- `MAX_STEP`, 31: step magnitude clamp, per axis.
- `SEARCH_STEP`, 8: pan step magnitude while sweeping.
- `SEARCH_LIMIT`, 200: sweep reversal bound on |pan_pos|.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `v_sync` in 1: frame sync; its rising edge defines a frame tick.
- `aim_x` in 10: tracker aim x.
- `aim_y` in 10: tracker aim y.
- `aim_detected` in 1: target seen in the last frame.
- `target_off` in 1: target lost for 3 s or more.
- `cmd_valid` out 1: step command pending.
- `cmd_ready` in 1: motor driver accepts the command.
- `cmd_pan` out 8: signed pan step.
- `cmd_tilt` out 8: signed tilt step.
- `pan_pos` out 12: signed accumulated pan.
- `tilt_pos` out 12: signed accumulated tilt.
- `state` out 3: IDLE=0, TRACK=1, HOLD=2, SEARCH=3, HOME=4.
- `lock` out 1: high in TRACK when both step values are 0.
- `drop_cnt` out 8: saturating count of frames dropped because of backpressure.

## Operation
- **Tick:** `v_sync` is registered once and edge-detected. `tick` is a 1-cycle pulse. All inputs are sampled, and all decisions are made, only on `tick`.
- **Command issue.** On `tick` with no command pending, the block loads `cmd_pan` and `cmd_tilt`, sets `cmd_valid`, and applies any state transition.
- **Backpressure.** On `tick` while `cmd_valid && !cmd_ready`, the frame is dropped:
  - No state change and no command update.
  - `drop_cnt` increments, saturating at 255.
- **Handshake.**
  - On `cmd_valid && cmd_ready`, `cmd_valid` clears the next cycle.
  - `pan_pos += cmd_pan` and `tilt_pos += cmd_tilt`, each sign-extended and saturated to ±2047.
  - `cmd_pan` and `cmd_tilt` are stable while `cmd_valid` is high.
- **Error arithmetic (TRACK).**
  - `ex = aim_x − CX` and `ey = aim_y − CY`, computed as signed 11-bit.
  - If |e| ≤ DEADBAND, the step is 0.
  - Otherwise the step is e >>> GAIN_SHIFT, clamped to ±MAX_STEP.
  - A non-deadband error whose shift gives 0 is forced to ±1.
- **IDLE.** Entered from reset. Issues no commands. On `tick` with `aim_detected` set, goes to TRACK.
- **TRACK.** Issues the error steps. On `tick` with `!aim_detected`, goes to HOLD.
- **HOLD.** Issues 0/0 commands.
  - On `tick` with `aim_detected` set, goes to TRACK.
  - Else on `tick` with `target_off` set, goes to SEARCH (or to HOME, see Configuration).
- **SEARCH.**
  - Pan step is ±SEARCH_STEP; tilt step is 0. The direction starts positive when entering from HOLD.
  - The direction flips when the projected pan_pos + step would exceed ±SEARCH_LIMIT. That tick's step is the opposite sign.
  - On `tick` with `aim_detected` set, goes to TRACK.
- **HOME.**
  - Per axis, the step is −sign(pos)·min(|pos|, MAX_STEP).
  - When pan_pos = tilt_pos = 0 at a tick, the block issues no command and goes to IDLE.
  - On `tick` with `aim_detected` set, goes to TRACK.
- **Precedence:** `aim_detected` is higher priority than `target_off` in every state.

## Timing
- **Latency:** `v_sync` rise at clk edge N gives `tick` at N+1 and `cmd_valid` at N+2.
- **Handshake completion:** `pan_pos` and `tilt_pos` update on the accept edge. `cmd_valid` is low the cycle after acceptance unless a `tick` coincides.
- **Accept and tick in the same cycle:** acceptance frees the slot. The new command loads, and `cmd_valid` stays high. Position accumulates the old command.
- **Reset values (`reset_n` low, asynchronous):**
  - `cmd_valid`=0, `cmd_pan`=0, `cmd_tilt`=0.
  - `pan_pos`=0, `tilt_pos`=0.
  - `state`=IDLE, `lock`=0, `drop_cnt`=0.
  - Search direction = +.
  - The registered `v_sync` history = 0.
- **Reset mid-handshake:** the pending command is discarded without accumulation.
- **`lock`:** registered, and updated with the command.

## Configuration
- **`TRACK_SEARCH_EN` defined:** SEARCH state is present as described above.
- **`TRACK_SEARCH_EN` undefined:**
  - SEARCH logic and the direction register are removed.
  - HOLD with `target_off` goes directly to HOME.
  - State encoding 3 is never produced.

## Test plan
- **Centring:** aim_x=400, aim_y=240 on a tick, `cmd_ready`=1 → cmd_pan=+10, cmd_tilt=0, pan_pos=10 after accept; aim_x=325 → cmd_pan=0, lock=1.
- **Clamp:** aim_x=639, aim_y=0 → cmd_pan=+31 (from 319>>>3=39, clamped), cmd_tilt=−30.
- **Backpressure:** `cmd_ready`=0 across 3 ticks → command unchanged, drop_cnt=2, pan_pos unchanged; then `cmd_ready`=1 → single accumulation.
- **Loss and search (`TRACK_SEARCH_EN` on):** aim_detected=0 → HOLD, 0/0 commands; target_off=1 → SEARCH, steps +8 until pan_pos=200; the next step is −8; aim_detected=1 → TRACK.
- **Home (`TRACK_SEARCH_EN` off):** pan_pos=−70, tilt_pos=5, target_off=1 in HOLD → HOME steps (+31,−5), (+31,0), (+8,0), then IDLE.
- **Async reset:** assert `reset_n` low while `cmd_valid`=1 → all outputs reach their reset values immediately, with no accumulation.

Source files
------------

// File: rtl/track_motor_scheduler.sv
// track_motor_scheduler: frame-rate pan/tilt step scheduler.
// Once per v_sync rising edge it samples the tracker, runs the
// IDLE/TRACK/HOLD/SEARCH/HOME state machine and offers one signed
// pan/tilt step over a valid/ready handshake. It also accumulates
// the saturated pan/tilt position.
// Optional feature macro: TRACK_SEARCH_EN enables the SEARCH sweep.
// Without this macro, HOLD falls back to HOME when the target is off.
module track_motor_scheduler #(
    parameter int CX           = 320,
    parameter int CY           = 240,
    parameter int DEADBAND     = 10,
    parameter int GAIN_SHIFT   = 3,
    parameter int MAX_STEP     = 31,
    parameter int SEARCH_STEP  = 8,
    parameter int SEARCH_LIMIT = 200
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               v_sync,
    input  logic [9:0]         aim_x,
    input  logic [9:0]         aim_y,
    input  logic               aim_detected,
    input  logic               target_off,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic signed [7:0]  cmd_pan,
    output logic signed [7:0]  cmd_tilt,
    output logic signed [11:0] pan_pos,
    output logic signed [11:0] tilt_pos,
    output logic [2:0]         state,
    output logic               lock,
    output logic [7:0]         drop_cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        TRACK  = 3'd1,
        HOLD   = 3'd2,
        SEARCH = 3'd3,
        HOME   = 3'd4
    } state_t;

    localparam logic [9:0]         CX_W    = 10'(CX);
    localparam logic [9:0]         CY_W    = 10'(CY);
    localparam logic signed [10:0] DB_W    = 11'(DEADBAND);
    localparam logic signed [10:0] MAX11   = 11'(MAX_STEP);
    localparam logic signed [11:0] MAX12   = 12'(MAX_STEP);
    localparam logic signed [12:0] POS_MAX = 13'sd2047;

    state_t             st;
    logic               v_sync_q;
    logic               tick;
    logic               accept;
    logic signed [11:0] proj_pan;
    logic signed [11:0] proj_tilt;

    state_t             nxt_st;
    logic signed [7:0]  nxt_pan;
    logic signed [7:0]  nxt_tilt;
    logic               nxt_issue;
    logic               nxt_lock;
    logic               go_home;

    // Signed error from the screen centre, then deadband, gain, clamp, and minimum step of 1.
    function automatic logic signed [7:0] err_step(input logic [9:0] aim, input logic [9:0] centre);
        logic signed [10:0] e;
        logic signed [10:0] mag;
        logic signed [10:0] sh;
        logic signed [10:0] s;
        e   = $signed({1'b0, aim}) - $signed({1'b0, centre});
        mag = (e < 11'sd0) ? -e : e;
        sh  = e >>> GAIN_SHIFT;
        if (mag <= DB_W)
            s = '0;
        else if (sh > MAX11)
            s = MAX11;
        else if (sh < -MAX11)
            s = -MAX11;
        else if (sh == 11'sd0)
            s = (e < 11'sd0) ? -11'sd1 : 11'sd1;
        else
            s = sh;
        return s[7:0];
    endfunction

    // Step toward zero, limited to MAX_STEP.
    function automatic logic signed [7:0] home_step(input logic signed [11:0] pos);
        logic signed [11:0] r;
        if (pos > MAX12)
            r = -MAX12;
        else if (pos < -MAX12)
            r = MAX12;
        else
            r = -pos;
        return r[7:0];
    endfunction

    // Add the sign-extended step, then saturate to +/-2047.
    function automatic logic signed [11:0] sat_add(input logic signed [11:0] pos, input logic signed [7:0] step);
        logic signed [12:0] sum;
        sum = {pos[11], pos} + {{5{step[7]}}, step};
        if (sum > POS_MAX)
            return 12'sd2047;
        else if (sum < -POS_MAX)
            return -12'sd2047;
        else
            return sum[11:0];
    endfunction

    assign accept = cmd_valid & cmd_ready;
    assign state  = st;

    // Home and search decisions use the position as it stands after any same-cycle accept.
    // This prevents the old command from being counted twice when computing the next step.
    assign proj_pan  = accept ? sat_add(pan_pos, cmd_pan)   : pan_pos;
    assign proj_tilt = accept ? sat_add(tilt_pos, cmd_tilt) : tilt_pos;

`ifdef TRACK_SEARCH_EN
    localparam logic signed [12:0] SSTEP13 = 13'(SEARCH_STEP);
    localparam logic signed [12:0] LIM13   = 13'(SEARCH_LIMIT);
    localparam logic signed [7:0]  SSTEP8  = 8'(SEARCH_STEP);

    logic               dir;
    logic               base_dir;
    logic               srch_dir;
    logic signed [12:0] reach;
    logic signed [7:0]  srch_step;

    // Sweep step: keep the current direction unless the projected position would pass the limit.
    always_comb begin
        base_dir  = (st == SEARCH) ? dir : 1'b1;
        reach     = {proj_pan[11], proj_pan} + (base_dir ? SSTEP13 : -SSTEP13);
        srch_dir  = ((reach > LIM13) || (reach < -LIM13)) ? ~base_dir : base_dir;
        srch_step = srch_dir ? SSTEP8 : -SSTEP8;
    end
`endif

    // Next state and command for this tick. The command follows the state being entered.
    always_comb begin
        nxt_st    = st;
        nxt_pan   = '0;
        nxt_tilt  = '0;
        nxt_issue = 1'b0;
        go_home   = 1'b0;
        if (aim_detected) begin
            nxt_st    = TRACK;
            nxt_pan   = err_step(aim_x, CX_W);
            nxt_tilt  = err_step(aim_y, CY_W);
            nxt_issue = 1'b1;
        end else begin
            case (st)
                TRACK: begin
                    nxt_st    = HOLD;
                    nxt_issue = 1'b1;
                end
                HOLD: begin
                    if (target_off) begin
`ifdef TRACK_SEARCH_EN
                        nxt_st    = SEARCH;
                        nxt_pan   = srch_step;
                        nxt_issue = 1'b1;
`else
                        go_home   = 1'b1;
`endif
                    end else begin
                        nxt_issue = 1'b1;
                    end
                end
`ifdef TRACK_SEARCH_EN
                SEARCH: begin
                    nxt_pan   = srch_step;
                    nxt_issue = 1'b1;
                end
`endif
                HOME:    go_home = 1'b1;
                default: nxt_st  = st;
            endcase
            if (go_home) begin
                if (proj_pan == '0 && proj_tilt == '0) begin
                    nxt_st = IDLE;
                end else begin
                    nxt_st    = HOME;
                    nxt_pan   = home_step(proj_pan);
                    nxt_tilt  = home_step(proj_tilt);
                    nxt_issue = 1'b1;
                end
            end
        end
        nxt_lock = nxt_issue && (nxt_st == TRACK) && (nxt_pan == '0) && (nxt_tilt == '0);
    end

    // Frame tick detection, handshake accumulation, drop counting and state/command registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_sync_q  <= 1'b0;
            tick      <= 1'b0;
            st        <= IDLE;
            cmd_valid <= 1'b0;
            cmd_pan   <= '0;
            cmd_tilt  <= '0;
            pan_pos   <= '0;
            tilt_pos  <= '0;
            lock      <= 1'b0;
            drop_cnt  <= '0;
`ifdef TRACK_SEARCH_EN
            dir       <= 1'b1;
`endif
        end else begin
            v_sync_q <= v_sync;
            tick     <= v_sync & ~v_sync_q;
            if (accept) begin
                pan_pos   <= proj_pan;
                tilt_pos  <= proj_tilt;
                cmd_valid <= 1'b0;
            end
            if (tick) begin
                if (cmd_valid && !cmd_ready) begin
                    if (drop_cnt != '1)
                        drop_cnt <= drop_cnt + 8'd1;
                end else begin
                    st   <= nxt_st;
                    lock <= nxt_lock;
                    if (nxt_issue) begin
                        cmd_valid <= 1'b1;
                        cmd_pan   <= nxt_pan;
                        cmd_tilt  <= nxt_tilt;
                    end
`ifdef TRACK_SEARCH_EN
                    if (nxt_st == SEARCH)
                        dir <= srch_dir;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_track_motor_scheduler.sv
// Testbench for track_motor_scheduler: table of frame vectors plus hand-written
// latency, backpressure, tick/accept overlap, drop saturation and reset sequences.
module tb_track_motor_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset_n;
    logic               v_sync;
    logic [9:0]         aim_x;
    logic [9:0]         aim_y;
    logic               aim_detected;
    logic               target_off;
    logic               cmd_valid;
    logic               cmd_ready;
    logic signed [7:0]  cmd_pan;
    logic signed [7:0]  cmd_tilt;
    logic signed [11:0] pan_pos;
    logic signed [11:0] tilt_pos;
    logic [2:0]         state;
    logic               lock;
    logic [7:0]         drop_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int mpan     = 0;
    int mtilt    = 0;
    int mdrop    = 0;

    typedef struct {int pan; int tilt; int st; int lk;} exp_t;
    typedef struct {int ax; int ay; int det; int toff; int issue; int pan; int tilt; int st; int lk;} vec_t;

    exp_t sbq[$];
    exp_t mon_e;
    vec_t vt[$];

    track_motor_scheduler dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .v_sync       (v_sync),
        .aim_x        (aim_x),
        .aim_y        (aim_y),
        .aim_detected (aim_detected),
        .target_off   (target_off),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_pan      (cmd_pan),
        .cmd_tilt     (cmd_tilt),
        .pan_pos      (pan_pos),
        .tilt_pos     (tilt_pos),
        .state        (state),
        .lock         (lock),
        .drop_cnt     (drop_cnt)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    function automatic void add_vec(input int ax, input int ay, input int det, input int toff,
                                    input int issue, input int pan, input int tilt, input int st, input int lk);
        vt.push_back(vec_t'{ax, ay, det, toff, issue, pan, tilt, st, lk});
    endfunction

    task automatic set_aim(input int ax, input int ay, input logic det, input logic toff);
        aim_x        = 10'(ax);
        aim_y        = 10'(ay);
        aim_detected = det;
        target_off   = toff;
    endtask

    // One frame: a rising v_sync edge followed by enough cycles to allow tick, issue and accept.
    task automatic frame();
        @(posedge clk); #1 v_sync = 1'b1;
        repeat (2) @(posedge clk);
        #1 v_sync = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Scoreboard: each handshake must match the oldest expected command.
    always @(negedge clk) begin
        if (reset_n && cmd_valid && cmd_ready) begin
            if (sbq.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_cmd: got pan=%0d tilt=%0d state=%0d, required no command",
                         cmd_pan, cmd_tilt, state);
            end else begin
                mon_e = sbq.pop_front();
                check("sb_pan",   cmd_pan,  mon_e.pan);
                check("sb_tilt",  cmd_tilt, mon_e.tilt);
                check("sb_state", state,    mon_e.st);
                check("sb_lock",  lock,     mon_e.lk);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        v_sync  = 1'b0;
        cmd_ready = 1'b1;
        set_aim(320, 240, 1'b0, 1'b0);

        // Vector table (ax, ay, det, toff, issue, pan, tilt, state, lock)
        add_vec(320, 240, 0, 1, 0,   0,   0, 0, 0); // IDLE ignores target_off
        add_vec(400, 240, 1, 0, 1,  10,   0, 1, 0); // centring
        add_vec(325, 240, 1, 0, 1,   0,   0, 1, 1); // inside deadband, lock
        add_vec(639,   0, 1, 0, 1,  31, -30, 1, 0); // clamp
        add_vec(331, 240, 1, 0, 1,   1,   0, 1, 0); // just outside deadband
        add_vec(309, 229, 1, 0, 1,  -2,  -2, 1, 0); // negative floor shift
        add_vec(330, 250, 1, 0, 1,   0,   0, 1, 1); // deadband edge
        add_vec(  0, 479, 1, 0, 1, -31,  29, 1, 0); // negative clamp
        add_vec(320, 240, 0, 1, 1,   0,   0, 2, 0); // TRACK -> HOLD
        add_vec(320, 240, 0, 0, 1,   0,   0, 2, 0); // HOLD waits
        add_vec(320, 240, 1, 1, 1,   0,   0, 1, 1); // aim_detected beats target_off
        add_vec(  0, 240, 1, 0, 1, -31,   0, 1, 0);
        add_vec(  0, 240, 1, 0, 1, -31,   0, 1, 0);
        add_vec(184, 304, 1, 0, 1, -17,   8, 1, 0); // now pan -70, tilt 5
        add_vec(320, 240, 0, 0, 1,   0,   0, 2, 0); // HOLD
`ifndef TRACK_SEARCH_EN
        add_vec(320, 240, 0, 1, 1,  31,  -5, 4, 0); // HOME
        add_vec(320, 240, 0, 1, 1,  31,   0, 4, 0);
        add_vec(320, 240, 0, 0, 1,   8,   0, 4, 0);
        add_vec(320, 240, 0, 0, 0,   0,   0, 0, 0); // at origin -> IDLE
`endif

        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_cmd_pan",   cmd_pan,   0);
        check("rst_cmd_tilt",  cmd_tilt,  0);
        check("rst_pan_pos",   pan_pos,   0);
        check("rst_tilt_pos",  tilt_pos,  0);
        check("rst_state",     state,     0);
        check("rst_lock",      lock,      0);
        check("rst_drop_cnt",  drop_cnt,  0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        foreach (vt[i]) begin
            set_aim(vt[i].ax, vt[i].ay, vt[i].det[0], vt[i].toff[0]);
            if (vt[i].issue != 0)
                sbq.push_back(exp_t'{vt[i].pan, vt[i].tilt, vt[i].st, vt[i].lk});
            frame();
            if (vt[i].issue != 0) begin
                mpan  += vt[i].pan;
                mtilt += vt[i].tilt;
            end
            check($sformatf("v%0d_state", i),    state,       vt[i].st);
            check($sformatf("v%0d_lock", i),     lock,        vt[i].lk);
            check($sformatf("v%0d_pan_pos", i),  pan_pos,     mpan);
            check($sformatf("v%0d_tilt_pos", i), tilt_pos,    mtilt);
            check($sformatf("v%0d_pending", i),  sbq.size(),  0);
            check($sformatf("v%0d_valid", i),    cmd_valid,   0);
        end

`ifdef TRACK_SEARCH_EN
        // Sweep from HOLD: model flips direction when the next position would pass +/-200.
        begin
            int dir = 1;
            int step;
            set_aim(320, 240, 1'b0, 1'b1);
            for (int k = 0; k < 40; k++) begin
                step = (dir != 0) ? 8 : -8;
                if (mpan + step > 200 || mpan + step < -200) begin
                    dir  = (dir != 0) ? 0 : 1;
                    step = -step;
                end
                sbq.push_back(exp_t'{step, 0, 3, 0});
                frame();
                mpan += step;
                check($sformatf("srch%0d_pan_pos", k), pan_pos, mpan);
            end
            check("srch_reversed_dir", dir, 0);
            set_aim(320, 240, 1'b1, 1'b1);
            sbq.push_back(exp_t'{0, 0, 1, 1});
            frame();
            check("srch_to_track", state, 1);
        end
`endif

        // Latency: v_sync driven after edge N gives cmd_valid after edge N+2.
        set_aim(400, 240, 1'b1, 1'b0);
        sbq.push_back(exp_t'{10, 0, 1, 0});
        @(posedge clk); #1 v_sync = 1'b1;
        @(posedge clk); #1 check("lat_valid_n1", cmd_valid, 0);
        @(posedge clk); #1 check("lat_valid_n2", cmd_valid, 1);
        v_sync = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        mpan += 10;
        check("lat_pan_pos", pan_pos, mpan);

        // Backpressure: three ticks with ready low give one command and two drops.
        cmd_ready = 1'b0;
        sbq.push_back(exp_t'{10, 0, 1, 0});
        frame();
        set_aim(639, 0, 1'b1, 1'b0);
        frame();
        frame();
        mdrop += 2;
        check("bp_drop_cnt", drop_cnt,  mdrop);
        check("bp_valid",    cmd_valid, 1);
        check("bp_cmd_pan",  cmd_pan,   10);
        check("bp_cmd_tilt", cmd_tilt,  0);
        check("bp_pan_pos",  pan_pos,   mpan);
        cmd_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mpan += 10;
        check("bp_release_pan_pos", pan_pos, mpan);
        check("bp_release_valid",   cmd_valid, 0);

        // Accept and tick in the same cycle: new command loads and the old one accumulates.
        cmd_ready = 1'b0;
        set_aim(639, 240, 1'b1, 1'b0);
        sbq.push_back(exp_t'{31, 0, 1, 0});
        frame();
        set_aim(240, 240, 1'b1, 1'b0);
        sbq.push_back(exp_t'{-10, 0, 1, 0});
        @(posedge clk); #1 v_sync = 1'b1;
        @(posedge clk); #1 cmd_ready = 1'b1;
        @(posedge clk); #1;
        mpan += 31;
        check("ovl_valid",   cmd_valid, 1);
        check("ovl_cmd_pan", cmd_pan,   -10);
        check("ovl_pan_pos", pan_pos,   mpan);
        v_sync = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mpan -= 10;
        check("ovl_final_pan_pos", pan_pos, mpan);
        check("ovl_drop_cnt",      drop_cnt, mdrop);

        // drop_cnt saturates at 255.
        cmd_ready = 1'b0;
        set_aim(400, 240, 1'b1, 1'b0);
        sbq.push_back(exp_t'{10, 0, 1, 0});
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1 v_sync = 1'b1;
            @(posedge clk); #1 v_sync = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        mdrop = (mdrop + 299 > 255) ? 255 : mdrop + 299;
        check("sat_drop_cnt", drop_cnt, mdrop);
        check("sat_pan_pos",  pan_pos,  mpan);
        cmd_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mpan += 10;
        check("sat_release_pan_pos", pan_pos, mpan);

        // Asynchronous reset with a command pending: no accumulation, immediate reset values.
        cmd_ready = 1'b0;
        set_aim(639, 479, 1'b1, 1'b0);
        frame();
        check("ar_pre_valid", cmd_valid, 1);
        @(posedge clk); #3 reset_n = 1'b0;
        #1;
        check("ar_valid",    cmd_valid, 0);
        check("ar_cmd_pan",  cmd_pan,   0);
        check("ar_cmd_tilt", cmd_tilt,  0);
        check("ar_pan_pos",  pan_pos,   0);
        check("ar_tilt_pos", tilt_pos,  0);
        check("ar_state",    state,     0);
        check("ar_lock",     lock,      0);
        check("ar_drop_cnt", drop_cnt,  0);
        cmd_ready = 1'b1;
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("ar_post_pan_pos", pan_pos,   0);
        check("ar_post_valid",   cmd_valid, 0);
        check("sb_drained",      sbq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
